// File: rtl/davinci_dataout_fifo.sv
// davinci_dataout_fifo: FWFT output FIFO for the DA-VinCi data stream with EOV counting and sticky flags
module davinci_dataout_fifo #(
  parameter int DATA_WIDTH   = 16,
  parameter int ATTRIB_WIDTH = 2,
  parameter int EOV_BIT      = 0,
  parameter int DEPTH        = 64,
  parameter int CNT_WIDTH    = $clog2(DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [DATA_WIDTH-1:0]   wrData,
  input  logic [ATTRIB_WIDTH-1:0] wrAttrib,
  input  logic                    wrValid,
  output logic [DATA_WIDTH-1:0]   rdData,
  output logic [ATTRIB_WIDTH-1:0] rdAttrib,
  output logic                    rdValid,
  input  logic                    rdReady,
  output logic [CNT_WIDTH-1:0]    level,
  output logic [CNT_WIDTH-1:0]    eovCount,
  output logic                    eovInterrupt,
  input  logic                    clearEOV,
  output logic                    overflow,
  input  logic                    clearOverflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = DATA_WIDTH + ATTRIB_WIDTH;
  logic [EW-1:0]        r_mem [DEPTH];
  logic [AW-1:0]        r_wptr, r_rptr;
  logic [CNT_WIDTH-1:0] r_level, r_eov;
  logic                 r_eoi, r_ovf;
  logic                 w_full, w_pop, w_push, w_drop, w_weov, w_reov;
  assign {rdAttrib, rdData} = r_mem[r_rptr];
  assign rdValid      = r_level != '0;
  assign w_full       = r_level == CNT_WIDTH'(DEPTH);
  assign w_pop        = rdValid & rdReady;
  // a pop at full frees the slot this same edge, so the write is still taken
  assign w_push       = wrValid & (!w_full | w_pop);
  assign w_drop       = wrValid & w_full & !w_pop;
  assign w_weov       = w_push & wrAttrib[EOV_BIT];
  assign w_reov       = w_pop & rdAttrib[EOV_BIT];
  assign level        = r_level;
  assign eovCount     = r_eov;
  assign eovInterrupt = r_eoi;
  assign overflow     = r_ovf;
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wptr] <= {wrAttrib, wrData};
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_eov   <= '0;
      r_eoi   <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_wptr  <= w_push ? r_wptr + AW'(1) : r_wptr;
      r_rptr  <= w_pop ? r_rptr + AW'(1) : r_rptr;
      r_level <= r_level + CNT_WIDTH'(w_push) - CNT_WIDTH'(w_pop);
      r_eov   <= r_eov + CNT_WIDTH'(w_weov) - CNT_WIDTH'(w_reov);
      r_eoi   <= w_weov | (r_eoi & !clearEOV);
      r_ovf   <= w_drop | (r_ovf & !clearOverflow);
    end
endmodule

// File: tb/tb_davinci_dataout_fifo.sv
// tb_davinci_dataout_fifo: directed stimulus with a queue-based reference model checked every cycle
module tb_davinci_dataout_fifo;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [15:0] wrData = '0;
  logic [1:0]  wrAttrib = '0;
  logic        wrValid = 1'b0;
  logic [15:0] rdData;
  logic [1:0]  rdAttrib;
  logic        rdValid;
  logic        rdReady = 1'b0;
  logic [6:0]  level, eovCount;
  logic        eovInterrupt, overflow;
  logic        clearEOV = 1'b0;
  logic        clearOverflow = 1'b0;
  int          checks = 0;
  int          errors = 0;
  logic [17:0] q[$];
  logic        m_eoi = 1'b0;
  logic        m_ovf = 1'b0;

  davinci_dataout_fifo dut (
    .clk(clk), .rstn(rstn), .wrData(wrData), .wrAttrib(wrAttrib), .wrValid(wrValid),
    .rdData(rdData), .rdAttrib(rdAttrib), .rdValid(rdValid), .rdReady(rdReady),
    .level(level), .eovCount(eovCount), .eovInterrupt(eovInterrupt), .clearEOV(clearEOV),
    .overflow(overflow), .clearOverflow(clearOverflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int eov_in_q();
    int n = 0;
    foreach (q[i]) if (q[i][16]) n++;
    return n;
  endfunction

  // one clock: apply inputs, let the edge happen, then advance the model with the same inputs
  task automatic cyc(input logic wv, input logic [15:0] d, input logic [1:0] a,
                     input logic rr, input logic ce = 1'b0, input logic co = 1'b0);
    logic pop, full, push, drop;
    wrValid = wv; wrData = d; wrAttrib = a; rdReady = rr; clearEOV = ce; clearOverflow = co;
    @(posedge clk);
    pop  = q.size() > 0 && rr;
    full = q.size() == 64;
    push = wv && (!full || pop);
    drop = wv && full && !pop;
    if (pop) void'(q.pop_front());
    if (push) q.push_back({a, d});
    m_eoi = (push && a[0]) ? 1'b1 : (ce ? 1'b0 : m_eoi);
    m_ovf = drop ? 1'b1 : (co ? 1'b0 : m_ovf);
    #1;
  endtask

  always @(negedge clk)
    if (rstn === 1'b1) begin
      chk("level", 32'(level), 32'(q.size()));
      chk("eovCount", 32'(eovCount), 32'(eov_in_q()));
      chk("rdValid", 32'(rdValid), 32'(q.size() > 0));
      chk("eovInterrupt", 32'(eovInterrupt), 32'(m_eoi));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      if (q.size() > 0) chk("head", 32'({rdAttrib, rdData}), 32'(q[0]));
    end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_level"}, 32'(level), 0);
    chk({tag, "_eov"}, 32'(eovCount), 0);
    chk({tag, "_rdValid"}, 32'(rdValid), 0);
    chk({tag, "_eoi"}, 32'(eovInterrupt), 0);
    chk({tag, "_ovf"}, 32'(overflow), 0);
  endtask

  initial begin
    #2 chk_all_zero("por");
    #10 rstn = 1'b1;
    // fill then overflow then drain
    for (int i = 0; i < 64; i++) cyc(1, 16'(i), 2'b00, 0);
    chk("fill_level", 32'(level), 64);
    chk("fill_ovf0", 32'(overflow), 0);
    cyc(1, 16'h0100, 2'b01, 0);
    chk("ovf_set", 32'(overflow), 1);
    chk("ovf_level", 32'(level), 64);
    chk("ovf_noeoi", 32'(eovInterrupt), 0);
    cyc(1, 16'h0101, 2'b00, 0);
    cyc(1, 16'h0102, 2'b00, 0);
    cyc(0, 0, 0, 0, 0, 1);
    chk("ovf_clr", 32'(overflow), 0);
    chk("drain_head", 32'(rdData), 0);
    for (int i = 0; i < 64; i++) cyc(0, 0, 0, 1);
    chk("drain_level", 32'(level), 0);
    // wrap-around streaming
    for (int i = 0; i < 200; i++) begin
      cyc(1, 16'(16'h1000 + i), 2'b10, 1);
      chk("stream_level", 32'(level), 1);
      chk("stream_data", 32'(rdData), 32'(16'h1000 + i));
    end
    cyc(0, 0, 0, 1);
    chk("stream_ovf", 32'(overflow), 0);
    // EOV tracking
    for (int i = 0; i < 10; i++) cyc(1, 16'(16'h2000 + i), (i == 4 || i == 9) ? 2'b01 : 2'b00, 0);
    chk("eov_cnt2", 32'(eovCount), 2);
    chk("eov_int", 32'(eovInterrupt), 1);
    cyc(0, 0, 0, 0, 1);
    chk("eov_clr", 32'(eovInterrupt), 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1);
    chk("eov_cnt1", 32'(eovCount), 1);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1);
    chk("eov_cnt0", 32'(eovCount), 0);
    chk("eov_lvl0", 32'(level), 0);
    // full with simultaneous read and write
    for (int i = 0; i < 64; i++) cyc(1, 16'(16'h3000 + i), 2'b00, 0);
    for (int i = 0; i < 10; i++) begin
      cyc(1, 16'(16'h3100 + i), 2'b00, 1);
      chk("fullrw_level", 32'(level), 64);
      chk("fullrw_ovf", 32'(overflow), 0);
    end
    chk("fullrw_head", 32'(rdData), 32'h300a);
    // drop colliding with clearOverflow
    cyc(1, 16'h3fff, 2'b00, 0, 0, 1);
    chk("ovf_collide", 32'(overflow), 1);
    for (int i = 0; i < 64; i++) cyc(0, 0, 0, 1);
    chk("redrain_level", 32'(level), 0);
    // 20 words, EOV on 3, last EOV push collides with clearEOV
    for (int i = 0; i < 20; i++)
      cyc(1, 16'(16'h4000 + i), (i == 5 || i == 10 || i == 19) ? 2'b01 : 2'b00, 0, i == 19);
    chk("eoi_collide", 32'(eovInterrupt), 1);
    chk("pre_rst_level", 32'(level), 20);
    chk("pre_rst_eov", 32'(eovCount), 3);
    chk("pre_rst_ovf", 32'(overflow), 1);
    // asynchronous reset between edges
    #1 rstn = 1'b0;
    #1 chk_all_zero("midrst");
    q.delete(); m_eoi = 1'b0; m_ovf = 1'b0;
    #1 rstn = 1'b1;
    cyc(1, 16'h5555, 2'b00, 0);
    chk("post_rst_level", 32'(level), 1);
    chk("post_rst_data", 32'(rdData), 32'h5555);
    cyc(0, 0, 0, 1);
    chk("post_rst_empty", 32'(rdValid), 0);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
